// File: rtl/mmio_tx_pkg.sv
// Shared constants for the mmio_tx I/O responder:
// default I/O addresses, status bit indices and TX FSM encodings.
package mmio_tx_pkg;

  localparam logic [31:0] TX_ADDR_DEF   = 32'h0000_7ff0;
  localparam logic [31:0] STAT_ADDR_DEF = 32'h0000_7ff4;
  localparam logic [31:0] HALT_ADDR_DEF = 32'h0000_7fff;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [3:0] pack_status(
    input logic empty,
    input logic full,
    input logic busy,
    input logic ovf
  );
    logic [3:0] s;
    s = '0;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    s[ST_BUSY]  = busy;
    s[ST_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// io_fifo: synchronous FIFO for the UART transmit path.
// Pushes while full and pops while empty are ignored.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmio_tx.sv
// mmio_tx: store-decoded I/O window with a FIFO-buffered
// 8N1 UART transmitter and a sticky halt/exit-code latch.
module mmio_tx
  import mmio_tx_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                CLKS_PER_BIT = 16,
  parameter int                FIFO_DEPTH   = 8,
  parameter logic [DATA_W-1:0] TX_ADDR      = DATA_W'(TX_ADDR_DEF),
  parameter logic [DATA_W-1:0] STAT_ADDR    = DATA_W'(STAT_ADDR_DEF),
  parameter logic [DATA_W-1:0] HALT_ADDR    = DATA_W'(HALT_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  output logic              sel,
  output logic [DATA_W-1:0] rd,
  output logic              txd,
  output logic              halt,
  output logic [DATA_W-1:0] halt_code
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              txd_q, txd_d;
  logic              halt_q, halt_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              ovf_q, ovf_d;

  logic       hit_tx, hit_stat, hit_halt;
  logic       tx_wr, pop;
  logic       empty, full, busy, baud_last;
  logic [7:0] head;

  assign hit_tx   = (addr == TX_ADDR);
  assign hit_stat = (addr == STAT_ADDR);
  assign hit_halt = (addr == HALT_ADDR);
  assign sel      = hit_tx || hit_stat || hit_halt;

  assign tx_wr     = we && hit_tx && !halt_q;
  assign busy      = (state_q != TX_IDLE);
  assign baud_last = (baud_q == BAUD_LAST);

  assign txd       = txd_q;
  assign halt      = halt_q;
  assign halt_code = code_q;

  io_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wr),
    .pop   (pop),
    .din   (wd[7:0]),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    rd = '0;
    if (hit_stat) begin
      rd[3:0] = pack_status(empty, full, busy, ovf_q);
    end
  end

  always_comb begin
    ovf_d  = ovf_q;
    halt_d = halt_q;
    code_d = code_q;
    if (tx_wr && full) begin
      ovf_d = 1'b1;
    end
    if (we && hit_stat && wd[ST_OVF]) begin
      ovf_d = 1'b0;
    end
    if (we && hit_halt && !halt_q) begin
      halt_d = 1'b1;
      code_d = wd;
    end
  end

  // txd_d is the line level for the state being entered, so txd
  // changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          bit_d   = '0;
          baud_d  = '0;
          state_d = TX_START;
          txd_d   = 1'b0;
        end
      end
      TX_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = TX_DATA;
          txd_d   = sh_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = {1'b0, sh_q[7:1]};
            txd_d = sh_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = TX_IDLE;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      halt_q  <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      halt_q  <= halt_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_tx.sv
// Directed bench for mmio_tx: decode table, UART frame timing,
// FIFO overflow, halt latch and mid-frame reset.
module tb_mmio_tx;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] A_TX   = 32'h7ff0;
  localparam logic [31:0] A_ST   = 32'h7ff4;
  localparam logic [31:0] A_HALT = 32'h7fff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = A_ST;
  logic [31:0] wd = '0;
  logic        sel, txd, halt;
  logic [31:0] rd, halt_code;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_tx #(
    .DATA_W       (32),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wd        (wd),
    .we        (we),
    .sel       (sel),
    .rd        (rd),
    .txd       (txd),
    .halt      (halt),
    .halt_code (halt_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        e_sel;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1;
    addr = a;
    wd = d;
    step();
    we = 1'b0;
    addr = A_ST;
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    logic [7:0] t;
    t = b;
    if (k <= CPB) return 1'b0;
    if (k <= 9 * CPB) return t[(k - CPB - 1) / CPB];
    return 1'b1;
  endfunction

  task automatic check_frame(input logic [7:0] b, input string tag);
    for (int k = 1; k <= FRAME; k++) begin
      step();
      if (k == 1) begin
        we = 1'b0;
        addr = A_ST;
      end
      chk($sformatf("%s_txd_k%0d", tag, k), 32'(txd), 32'(exp_bit(b, k)));
      if (k == FRAME) chk({tag, "_busy_end"}, 32'(rd[2]), 32'd1);
    end
    step();
    chk({tag, "_idle_txd"}, 32'(txd), 32'd1);
    chk({tag, "_busy_fall"}, 32'(rd[2]), 32'd0);
  endtask

  task automatic rx_byte(output logic [7:0] b);
    logic found;
    found = 1'b0;
    b = '0;
    for (int t = 0; t < 200; t++) begin
      step();
      if (!txd) begin
        found = 1'b1;
        break;
      end
    end
    chk("rx_start_seen", 32'(found), 32'd1);
    for (int c = 2; c <= FRAME + 1; c++) begin
      step();
      if (c >= CPB + 2 && c <= 9 * CPB - 2 && (c - CPB - 2) % CPB == 0)
        b[(c - CPB - 2) / CPB] = txd;
      if (c == 9 * CPB + 2) chk("rx_stop", 32'(txd), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;

    vt[0] = '{1'b0, 32'h100,      32'h0,  1'b0, 32'h0};
    vt[1] = '{1'b0, A_ST,         32'h0,  1'b1, 32'h1};
    vt[2] = '{1'b0, A_TX,         32'h0,  1'b1, 32'h0};
    vt[3] = '{1'b0, A_HALT,       32'h0,  1'b1, 32'h0};
    vt[4] = '{1'b1, 32'h7ff8,     32'hAB, 1'b0, 32'h0};
    vt[5] = '{1'b1, A_ST,         32'hF,  1'b1, 32'h1};
    vt[6] = '{1'b0, A_ST,         32'h0,  1'b1, 32'h1};
    vt[7] = '{1'b0, 32'h7ff5,     32'h0,  1'b0, 32'h0};
    vt[8] = '{1'b0, 32'h0,        32'h0,  1'b0, 32'h0};
    vt[9] = '{1'b0, 32'hFFFF7FF4, 32'h0,  1'b0, 32'h0};

    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_code", halt_code, 32'h0);
    chk("rst_status", rd, 32'h1);

    for (int i = 0; i < 10; i++) begin
      we = vt[i].we;
      addr = vt[i].addr;
      wd = vt[i].wd;
      #1;
      chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vt[i].e_sel));
      chk($sformatf("vec%0d_rd", i), rd, vt[i].e_rd);
      step();
    end
    we = 1'b0;
    addr = A_ST;
    #1;

    store(A_TX, 32'h55);
    check_frame(8'h55, "b55");

    we = 1'b1;
    addr = A_TX;
    wd = 32'hA0;
    step();
    wd = 32'h0F;
    check_frame(8'hA0, "bA0");
    check_frame(8'h0F, "b0F");
    chk("pair_status", rd, 32'h1);

    store(A_TX, 32'h11);
    step();
    step();
    we = 1'b1;
    addr = A_TX;
    for (int i = 1; i <= 9; i++) begin
      wd = 32'(i);
      step();
    end
    we = 1'b0;
    addr = A_ST;
    #1;
    chk("ovf_status", rd, 32'hE);
    store(A_ST, 32'h8);
    chk("ovf_cleared", rd, 32'h6);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (!rd[2]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("first_frame_done", 32'(ok), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      rx_byte(b);
      chk($sformatf("rx_byte%0d", i), 32'(b), 32'(i));
    end
    ok = 1'b1;
    for (int t = 0; t < 60; t++) begin
      step();
      if (!txd) ok = 1'b0;
    end
    chk("ninth_dropped", 32'(ok), 32'd1);
    chk("drained_status", rd, 32'h1);

    we = 1'b1;
    addr = A_TX;
    wd = 32'h34;
    step();
    addr = A_HALT;
    wd = 32'h0000_1234;
    step();
    we = 1'b0;
    addr = A_ST;
    #1;
    chk("halt_set", 32'(halt), 32'd1);
    chk("halt_code", halt_code, 32'h1234);
    we = 1'b1;
    addr = A_HALT;
    wd = 32'hFFFF;
    step();
    addr = A_TX;
    wd = 32'h99;
    step();
    we = 1'b0;
    addr = A_ST;
    #1;
    chk("halt_code_kept", halt_code, 32'h1234);
    chk("halt_tx_ignored", rd, 32'h5);
    for (int t = 0; t < 15; t++) step();
    chk("data_bit3", 32'(txd), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_status", rd, 32'h1);
    chk("midrst_halt", 32'(halt), 32'd0);
    chk("midrst_code", halt_code, 32'h0);
    ok = 1'b1;
    for (int t = 0; t < 50; t++) begin
      step();
      if (!txd) ok = 1'b0;
    end
    chk("no_resume", 32'(ok), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_tx.md
# mmio_tx

Memory-mapped output responder on the mipse data bus, beside dmem. It decodes CPU stores to a small I/O window and buffers transmit bytes in a FIFO. Buffered bytes are serialised as 8N1 UART frames on `txd`. A store to the halt address is latched as a sticky halt flag plus a 32-bit exit code for the bench and top level.

## Interface
- `DATA_W`, 32: bus data/address width.
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥2.
- `FIFO_DEPTH`, 8: transmit FIFO entries; must be a power of 2.
- `TX_ADDR`, 32'h7ff0: store here pushes `wd[7:0]` into the FIFO.
- `STAT_ADDR`, 32'h7ff4: status register; readable and writable.
- `HALT_ADDR`, 32'h7fff: store here halts.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr` in DATA_W: CPU data address (aluresult).
- `wd` in DATA_W: CPU store data (writedata).
- `we` in 1: CPU store strobe (memwrite).
- `sel` out 1: combinational; 1 when `addr` equals any of the three I/O addresses.
- `rd` out DATA_W: combinational read data. Equals the status word when `addr==STAT_ADDR`, else 0. Top level muxes it over dmem when `sel`.
- `txd` out 1: registered serial output; idles high.
- `halt` out 1: registered, sticky until reset.
- `halt_code` out DATA_W: registered; holds `wd` captured by the halt store.

## Operation
- Reset values: `txd=1`, `halt=0`, `halt_code=0`. FIFO is emptied; overflow flag is 0; FSM is in IDLE.
- TX push: `we && addr==TX_ADDR && !full && !halt` writes `wd[7:0]`.
  - If `full`, the byte is dropped and sticky `ovf` is set.
  - A pop in the same cycle does NOT make room; acceptance depends only on `full` sampled that cycle.
  - After `halt`, TX stores are ignored without setting `ovf`. Queued bytes still drain.
- Status word: bit0 `empty`, bit1 `full`, bit2 `busy` (FSM not IDLE), bit3 `ovf`, bits [31:4] are 0.
- Status write: `we && addr==STAT_ADDR && wd[3]` clears `ovf`. Other bits are read-only.
- Halt: `we && addr==HALT_ADDR` sets `halt=1` and `halt_code=wd`. Only the first halt store is captured; later ones are ignored.
- Stores to any other address are ignored.
- FIFO rules:
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- TX FSM states:
  - IDLE: `txd=1`. If `!empty`, pop the head into the shift register, clear the bit counter, and go to START.
  - START: `txd=0` for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `txd=1` for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. It reloads on every state or bit change.

## Timing
- A store sampled at edge E to an empty FIFO in IDLE: `empty` falls after E. At edge E+1 the FSM pops and `txd` goes 0.
- One frame occupies the line for exactly 10·CLKS_PER_BIT cycles. It ends with `txd` high as the FSM enters IDLE.
- Back-to-back bytes: exactly one IDLE cycle separates a STOP from the next START.
- `halt` and `halt_code` are valid the cycle after the halt store edge.
- `rd` and `sel` have zero latency. Status reflects state registered at the last edge.
- Reset asserted mid-frame: at the next edge `txd=1` and the FSM enters IDLE. FIFO contents are discarded. No partial frame resumes after reset.

## Structure
- Add to `def.h`:
  - the three default I/O addresses;
  - the status bit indices `ST_EMPTY=0`, `ST_FULL=1`, `ST_BUSY=2`, `ST_OVF=3`;
  - the FSM state encodings (2 bits).
- One sub-module, `io_fifo`: synchronous FIFO parameterised by width (8) and depth, with `push`, `pop`, `din`, `dout`, `empty`, `full`, and the same `clk`/`rst`.
- Bus decode, halt latch and TX FSM live in `mmio_tx`.

## Test plan
- Single byte 0x55, CLKS_PER_BIT=4: store at edge E.
  - `txd` low E+1..E+4, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - `busy` falls at E+41.
- Two stores 0xA0 then 0x0F on consecutive cycles: two full frames separated by exactly one `txd=1` IDLE cycle. Bit order is LSB first.
- Nine stores in consecutive cycles with depth 8 and the FSM stalled mid-frame.
  - Status reads `full=1`, `ovf=1`; the ninth byte never appears on `txd`.
  - Writing STAT_ADDR with 0x8 then clears `ovf`.
- Halt: store 0x00001234 to 32'h7fff.
  - Next cycle `halt=1`, `halt_code=32'h1234`.
  - A later halt store of 0xFFFF leaves the code unchanged.
  - A TX store after halt is ignored and `ovf` stays 0.
- Reset asserted during DATA bit 3 for one cycle: next edge `txd=1`, status reads 0x1 (empty), `halt=0`.
- Read of `addr=0x100`: `sel=0`, `rd=0`. Read of STAT_ADDR when idle and empty: `sel=1`, `rd=32'h1`.
